tl_phase_ctrl: RTL and testbench

Phase sequencer for the two-road intersection. It owns the 1 s tick and walks the six-phase light cycle: X green, X yellow, all-red, Y green, Y yellow, all-red. It drives the per-road lamp outputs and the countdown value shown on the segment display. It also takes a pedestrian request (level in, single-cycle ack out) and a flash/maintenance override.

---
 rtl/tl_pkg.sv | 41 ++++
 rtl/tl_tick_gen.sv | 42 ++++
 rtl/tl_phase_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tl_phase_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// ----------------------------------------------------------------------------
// tl_pkg
// Shared types and constants for the two-road traffic-light phase sequencer.
//   tl_state_e  : phase encoding, also driven out on tl_phase_ctrl.phase
//   LAMP_*      : one-hot lamp patterns {R,Y,G}
//   tl_next_state() : successor in the normal six-phase cycle
// ----------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [2:0] {
    ST_XG    = 3'd0,  // X green
    ST_XY    = 3'd1,  // X yellow
    ST_AR1   = 3'd2,  // all red, X -> Y changeover
    ST_YG    = 3'd3,  // Y green
    ST_YY    = 3'd4,  // Y yellow
    ST_AR2   = 3'd5,  // all red, Y -> X changeover
    ST_FLASH = 3'd6   // maintenance flash
  } tl_state_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Normal cycle order. FLASH is left via its own exit path, never through
  // this function; it maps to XG only as a safe fallback.
  function automatic tl_state_e tl_next_state(input tl_state_e s);
    tl_state_e n;
    case (s)
      ST_XG:   n = ST_XY;
      ST_XY:   n = ST_AR1;
      ST_AR1:  n = ST_YG;
      ST_YG:   n = ST_YY;
      ST_YY:   n = ST_AR2;
      ST_AR2:  n = ST_XG;
      default: n = ST_XG;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// ----------------------------------------------------------------------------
// tl_tick_gen
// Prescaler producing the one-second tick for the phase sequencer.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   sec_tick out registered one-cycle pulse, high in the cycle after the
//                prescaler reaches CLK_DIV-1 (first tick CLK_DIV cycles
//                after reset release)
// ----------------------------------------------------------------------------
module tl_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic sec_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_q == PRESC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign sec_tick = tick_q;

endmodule

// File: rtl/tl_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tl_phase_ctrl
// Six-phase sequencer for a two-road intersection with pedestrian request
// handling and a flash/maintenance override. All outputs are registered.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ped_req   in   pedestrian request (level)
//   flash_en  in   flash override request (level)
//   light_x   out  X lamps, one-hot {R,Y,G}
//   light_y   out  Y lamps, one-hot {R,Y,G}
//   count     out  ticks remaining in current phase minus one
//   phase     out  current state (tl_state_e encoding)
//   sec_tick  out  one-cycle pulse per tick
//   ped_ack   out  one-cycle pulse when a pending request is served
// ----------------------------------------------------------------------------
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int TG_X    = 30,
  parameter int TG_Y    = 15,
  parameter int TY      = 3,
  parameter int TR      = 1,
  parameter int TPED    = 8,
  parameter int PED_CUT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] light_x,
  output logic [2:0] light_y,
  output logic [7:0] count,
  output logic [2:0] phase,
  output logic       sec_tick,
  output logic       ped_ack
);

  // Durations stored as "ticks minus one" so count==0 marks the last tick.
  localparam logic [7:0] TG_X_M1    = 8'(TG_X - 1);
  localparam logic [7:0] TG_Y_M1    = 8'(TG_Y - 1);
  localparam logic [7:0] TY_M1      = 8'(TY - 1);
  localparam logic [7:0] TR_M1      = 8'(TR - 1);
  localparam logic [7:0] TPED_M1    = 8'(TPED - 1);
  localparam logic [7:0] PED_CUT_M1 = 8'(PED_CUT - 1);

  logic tick;

  tl_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .sec_tick (tick)
  );

  tl_state_e  state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       blink_q, blink_d;
  logic       pending_q, pending_d;
  logic       ack_q, ack_d;
  logic [2:0] light_x_q, light_x_d;
  logic [2:0] light_y_q, light_y_d;

  tl_state_e  adv_state;
  logic [7:0] adv_count;
  logic       adv_is_ar;
  logic       in_green;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_XG;
      count_q   <= TG_X_M1;
      blink_q   <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      light_x_q <= LAMP_G;
      light_y_q <= LAMP_R;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      blink_q   <= blink_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      light_x_q <= light_x_d;
      light_y_q <= light_y_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Successor and its load value for a normal phase expiry. The all-red
  // phases stretch to TPED when they are serving a pedestrian request.
  always_comb begin
    adv_state = tl_next_state(state_q);
    adv_is_ar = (adv_state == ST_AR1) || (adv_state == ST_AR2);
    case (adv_state)
      ST_XG:   adv_count = TG_X_M1;
      ST_XY:   adv_count = TY_M1;
      ST_YG:   adv_count = TG_Y_M1;
      ST_YY:   adv_count = TY_M1;
      ST_AR1,
      ST_AR2:  adv_count = pending_q ? TPED_M1 : TR_M1;
      default: adv_count = TG_X_M1;
    endcase
    in_green = (state_q == ST_XG) || (state_q == ST_YG);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    blink_d   = blink_q;
    // A request is latched on any cycle; the clear below only fires on the
    // serving tick and re-reads ped_req so a simultaneous set wins.
    pending_d = pending_q | ped_req;
    ack_d     = 1'b0;

    if (tick) begin
      if (flash_en) begin
        // Entering FLASH starts with lamps lit; staying in FLASH toggles.
        state_d = ST_FLASH;
        count_d = 8'd0;
        blink_d = (state_q == ST_FLASH) ? ~blink_q : 1'b1;
      end else if (state_q == ST_FLASH) begin
        // Recovery always uses the short all-red, and does not serve a
        // held request; that waits for the next normal changeover.
        state_d = ST_AR2;
        count_d = TR_M1;
        blink_d = 1'b0;
      end else if (count_q == 8'd0) begin
        state_d = adv_state;
        count_d = adv_count;
        if (adv_is_ar && pending_q) begin
          pending_d = ped_req;
          ack_d     = 1'b1;
        end
      end else if (in_green && pending_q && (count_q > PED_CUT_M1)) begin
        count_d = PED_CUT_M1;
      end else begin
        count_d = count_q - 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: lamps are decoded from the next state so that the lamp
  // registers change on the same edge as the phase register.
  // --------------------------------------------------------------------------
  always_comb begin
    light_x_d = LAMP_R;
    light_y_d = LAMP_R;
    case (state_d)
      ST_XG: begin
        light_x_d = LAMP_G;
        light_y_d = LAMP_R;
      end
      ST_XY: begin
        light_x_d = LAMP_Y;
        light_y_d = LAMP_R;
      end
      ST_YG: begin
        light_x_d = LAMP_R;
        light_y_d = LAMP_G;
      end
      ST_YY: begin
        light_x_d = LAMP_R;
        light_y_d = LAMP_Y;
      end
      ST_FLASH: begin
        light_x_d = blink_d ? LAMP_Y : LAMP_OFF;
        light_y_d = blink_d ? LAMP_Y : LAMP_OFF;
      end
      default: begin
        light_x_d = LAMP_R;
        light_y_d = LAMP_R;
      end
    endcase
  end

  assign light_x  = light_x_q;
  assign light_y  = light_y_q;
  assign count    = count_q;
  assign phase    = state_q;
  assign sec_tick = tick;
  assign ped_ack  = ack_q;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tl_phase_ctrl
// Directed self-checking bench for tl_phase_ctrl with CLK_DIV=4, TG_X=5,
// TG_Y=3, TY=2, TR=1, TPED=4, PED_CUT=2. Outputs are sampled on the falling
// edge; inputs change on the falling edge.
// ----------------------------------------------------------------------------
module tb_tl_phase_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] light_x, light_y, phase;
  logic [7:0] count;
  logic       sec_tick, ped_ack;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_tick_cyc = 0;

  tl_phase_ctrl #(
    .CLK_DIV (4), .TG_X (5), .TG_Y (3), .TY (2), .TR (1), .TPED (4), .PED_CUT (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .light_x  (light_x),
    .light_y  (light_y),
    .count    (count),
    .phase    (phase),
    .sec_tick (sec_tick),
    .ped_ack  (ped_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hold reset for two cycles and release on a falling edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the tick cycle, then one more falling edge so the
  // state updated by that tick is visible.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * CLK_DIV && !seen; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL tick_timeout: sec_tick=0 for %0d cycles, required a tick", 2 * CLK_DIV);
    end
    last_tick_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (phase !== 3'd0 || count !== 8'd4 || light_x !== 3'b001 || light_y !== 3'b100
        || sec_tick !== 1'b0 || ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: phase=%0d count=%0d lx=%b ly=%b tick=%b ack=%b, required 0 4 001 100 0 0",
               phase, count, light_x, light_y, sec_tick, ped_ack);
    end
    n = 0;
    for (int i = 1; i <= 2 * CLK_DIV && n == 0; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) n = i;
    end
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL first_tick_latency: %0d cycles, required 4", n);
    end
    @(negedge clk);
    checks++;
    if (count !== 8'd3 || phase !== 3'd0 || sec_tick !== 1'b0) begin
      fails++;
      $display("FAIL first_tick_count: phase=%0d count=%0d tick=%b, required 0 3 0", phase, count, sec_tick);
    end
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    logic [2:0] ph_tab [14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                                3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    logic [7:0] ct_tab [14] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0,
                                8'd2, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd4};
    logic [2:0] lx_tab [14] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] ly_tab [14] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    int first_cyc;
    do_reset();
    wait_tick();  // -> XG 3
    first_cyc = last_tick_cyc;
    checks++;
    if (phase !== 3'd0 || count !== 8'd3) begin
      fails++;
      $display("FAIL free_run_start: phase=%0d count=%0d, required 0 3", phase, count);
    end
    for (int k = 0; k < 14; k++) begin
      wait_tick();
      checks++;
      if (phase !== ph_tab[k] || count !== ct_tab[(k+1)%14] && k == 13 ? 1'b0 : 1'b0) begin end
      // Table is indexed by the tick after the starting XG 3.
      if (k < 13) begin
        if (phase !== ph_tab[k+1] || count !== ct_tab[k+1] || light_x !== lx_tab[k+1]
            || light_y !== ly_tab[k+1] || ped_ack !== 1'b0) begin
          fails++;
          $display("FAIL free_run_step%0d: phase=%0d count=%0d lx=%b ly=%b ack=%b, required %0d %0d %b %b 0",
                   k, phase, count, light_x, light_y, ped_ack,
                   ph_tab[k+1], ct_tab[k+1], lx_tab[k+1], ly_tab[k+1]);
        end
      end else begin
        // 14th tick after the start: back to XG 3 one full period later.
        if (phase !== 3'd0 || count !== 8'd3 || light_x !== 3'b001 || light_y !== 3'b100) begin
          fails++;
          $display("FAIL free_run_wrap: phase=%0d count=%0d lx=%b ly=%b, required 0 3 001 100",
                   phase, count, light_x, light_y);
        end
      end
    end
    checks++;
    if (last_tick_cyc - first_cyc != 56) begin
      fails++;
      $display("FAIL free_run_period: %0d cycles, required 56", last_tick_cyc - first_cyc);
    end
    $display("test_free_run done");
  endtask

  task automatic test_ped_truncate();
    logic [2:0] ph_tab [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [7:0] ct_tab [4] = '{8'd1, 8'd0, 8'd1, 8'd0};
    do_reset();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      checks++;
      if (phase !== ph_tab[k] || count !== ct_tab[k] || ped_ack !== 1'b0) begin
        fails++;
        $display("FAIL ped_trunc_step%0d: phase=%0d count=%0d ack=%b, required %0d %0d 0",
                 k, phase, count, ped_ack, ph_tab[k], ct_tab[k]);
      end
    end
    wait_tick();  // -> AR1 loaded with TPED-1
    checks++;
    if (phase !== 3'd2 || count !== 8'd3 || ped_ack !== 1'b1 || light_x !== 3'b100 || light_y !== 3'b100) begin
      fails++;
      $display("FAIL ped_ar1_entry: phase=%0d count=%0d ack=%b lx=%b ly=%b, required 2 3 1 100 100",
               phase, count, ped_ack, light_x, light_y);
    end
    @(negedge clk);
    checks++;
    if (ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL ped_ack_width: ack=%b one cycle later, required 0", ped_ack);
    end
    // AR1 2,1,0 then YG 2,1,0, YY 1,0, then AR2 with the short all-red.
    repeat (8) wait_tick();
    wait_tick();
    checks++;
    if (phase !== 3'd5 || count !== 8'd0 || ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL ped_ar2_after_clear: phase=%0d count=%0d ack=%b, required 5 0 0", phase, count, ped_ack);
    end
    $display("test_ped_truncate done");
  endtask

  task automatic test_ped_no_trunc_hold();
    do_reset();
    repeat (9) wait_tick();  // -> YG 1
    checks++;
    if (phase !== 3'd3 || count !== 8'd1) begin
      fails++;
      $display("FAIL hold_setup: phase=%0d count=%0d, required 3 1", phase, count);
    end
    ped_req = 1'b1;
    wait_tick();
    checks++;
    if (phase !== 3'd3 || count !== 8'd0) begin
      fails++;
      $display("FAIL hold_no_trunc: phase=%0d count=%0d, required 3 0", phase, count);
    end
    repeat (2) wait_tick();  // YY 1, YY 0
    wait_tick();
    checks++;
    if (phase !== 3'd5 || count !== 8'd3 || ped_ack !== 1'b1) begin
      fails++;
      $display("FAIL hold_ar2_entry: phase=%0d count=%0d ack=%b, required 5 3 1", phase, count, ped_ack);
    end
    @(negedge clk);
    checks++;
    if (ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL hold_ack_width: ack=%b, required 0", ped_ack);
    end
    ped_req = 1'b0;
    repeat (3) wait_tick();  // AR2 2,1,0
    wait_tick();
    checks++;
    if (phase !== 3'd0 || count !== 8'd4 || ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL hold_xg_entry: phase=%0d count=%0d ack=%b, required 0 4 0", phase, count, ped_ack);
    end
    wait_tick();  // request still pending -> truncation
    checks++;
    if (phase !== 3'd0 || count !== 8'd1) begin
      fails++;
      $display("FAIL hold_pending_kept: phase=%0d count=%0d, required 0 1", phase, count);
    end
    $display("test_ped_no_trunc_hold done");
  endtask

  task automatic test_flash();
    do_reset();
    repeat (8) wait_tick();  // -> YG 2
    checks++;
    if (phase !== 3'd3 || count !== 8'd2) begin
      fails++;
      $display("FAIL flash_setup: phase=%0d count=%0d, required 3 2", phase, count);
    end
    flash_en = 1'b1;
    wait_tick();
    checks++;
    if (phase !== 3'd6 || count !== 8'd0 || light_x !== 3'b010 || light_y !== 3'b010) begin
      fails++;
      $display("FAIL flash_entry: phase=%0d count=%0d lx=%b ly=%b, required 6 0 010 010",
               phase, count, light_x, light_y);
    end
    wait_tick();
    checks++;
    if (phase !== 3'd6 || light_x !== 3'b000 || light_y !== 3'b000) begin
      fails++;
      $display("FAIL flash_blink_off: phase=%0d lx=%b ly=%b, required 6 000 000", phase, light_x, light_y);
    end
    flash_en = 1'b0;
    wait_tick();
    checks++;
    if (phase !== 3'd5 || count !== 8'd0 || light_x !== 3'b100 || light_y !== 3'b100 || ped_ack !== 1'b0) begin
      fails++;
      $display("FAIL flash_exit: phase=%0d count=%0d lx=%b ly=%b ack=%b, required 5 0 100 100 0",
               phase, count, light_x, light_y, ped_ack);
    end
    wait_tick();
    checks++;
    if (phase !== 3'd0 || count !== 8'd4 || light_x !== 3'b001 || light_y !== 3'b100) begin
      fails++;
      $display("FAIL flash_resume: phase=%0d count=%0d lx=%b ly=%b, required 0 4 001 100",
               phase, count, light_x, light_y);
    end
    $display("test_flash done");
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    repeat (3) wait_tick();  // XG 1 (truncated), XG 0, XY 1
    checks++;
    if (phase !== 3'd1 || count !== 8'd1) begin
      fails++;
      $display("FAIL areset_setup: phase=%0d count=%0d, required 1 1", phase, count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0 || count !== 8'd4 || ped_ack !== 1'b0 || light_x !== 3'b001 || light_y !== 3'b100) begin
      fails++;
      $display("FAIL areset_immediate: phase=%0d count=%0d ack=%b lx=%b ly=%b, required 0 4 0 001 100",
               phase, count, ped_ack, light_x, light_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 2 * CLK_DIV && n == 0; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) n = i;
    end
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL areset_tick_latency: %0d cycles, required 4", n);
    end
    @(negedge clk);
    checks++;
    if (phase !== 3'd0 || count !== 8'd3) begin
      fails++;
      $display("FAIL areset_pending_cleared: phase=%0d count=%0d, required 0 3", phase, count);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_truncate();
    test_ped_no_trunc_hold();
    test_flash();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
